// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters,
// one word per grant, with optional bus locking for multi-word loads.
module spi_bus_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_W        = 24,
    parameter int START_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_dir,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]      req_depth,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_done,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      m_ready,
    input  logic [DATA_W-1:0]         m_rx_data,
    output logic                      m_start,
    output logic                      m_dir,
    output logic [DATA_W-1:0]         m_data_tx,
    output logic [7:0]                m_depth,
    output logic                      busy,
    output logic [2:0]                grant_id
);

    localparam int          CNT_W     = $clog2(START_TIMEOUT + 1);
    localparam int unsigned NREQ      = NUM_REQ;
    localparam logic [7:0]  DEPTH_MAX = 8'(DATA_W);
    localparam logic [2:0]  LAST_ID   = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          rr_ptr_q, rr_ptr_d;
    logic                lock_active_q, lock_active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cap_dir_q, cap_dir_d;
    logic                cap_lock_q, cap_lock_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d;
    logic [7:0]          cap_depth_q, cap_depth_d;

    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_done_q, rsp_done_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                m_start_q, m_start_d;
    logic                m_dir_q, m_dir_d;
    logic [DATA_W-1:0]   m_data_tx_q, m_data_tx_d;
    logic [7:0]          m_depth_q, m_depth_d;
    logic                busy_q, busy_d;
    logic [2:0]          grant_id_q, grant_id_d;

    logic                arb_found;
    logic [2:0]          arb_idx;
    logic [NUM_REQ-1:0]  arb_onehot;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                sel_dir;
    logic                sel_lock;
    logic [DATA_W-1:0]   sel_data;
    logic [7:0]          sel_depth_raw;
    logic [7:0]          sel_depth;
    logic [2:0]          rr_next;
    int unsigned         cand;

    // Under lock only the holder is eligible; otherwise search upward from rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        if (lock_active_q) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (3'(j) == grant_id_q && req_valid[j]) begin
                    arb_found = 1'b1;
                    arb_idx   = 3'(j);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                cand = 32'(rr_ptr_q) + i;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (!arb_found && j == cand && req_valid[j]) begin
                        arb_found = 1'b1;
                        arb_idx   = 3'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_dir       = 1'b0;
        sel_lock      = 1'b0;
        sel_data      = '0;
        sel_depth_raw = '0;
        arb_onehot    = '0;
        grant_onehot  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (3'(j) == arb_idx) begin
                sel_dir       = req_dir[j];
                sel_lock      = req_lock[j];
                sel_data      = req_data[j*DATA_W +: DATA_W];
                sel_depth_raw = req_depth[j*8 +: 8];
                arb_onehot[j] = 1'b1;
            end
            grant_onehot[j] = (3'(j) == grant_id_q);
        end
        sel_depth = (sel_depth_raw > DEPTH_MAX) ? DEPTH_MAX : sel_depth_raw;
        rr_next   = (grant_id_q == LAST_ID) ? 3'd0 : grant_id_q + 3'd1;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_active_d = lock_active_q;
        cnt_d         = cnt_q;
        cap_dir_d     = cap_dir_q;
        cap_lock_d    = cap_lock_q;
        cap_data_d    = cap_data_q;
        cap_depth_d   = cap_depth_q;
        req_ready_d   = '0;
        rsp_done_d    = '0;
        rsp_err_d     = 1'b0;
        rsp_data_d    = rsp_data_q;
        m_start_d     = 1'b0;
        m_dir_d       = m_dir_q;
        m_data_tx_d   = m_data_tx_q;
        m_depth_d     = m_depth_q;
        grant_id_d    = grant_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (m_ready && arb_found) begin
                    req_ready_d = arb_onehot;
                    cap_dir_d   = sel_dir;
                    cap_lock_d  = sel_lock;
                    cap_data_d  = sel_data;
                    cap_depth_d = sel_depth;
                    grant_id_d  = arb_idx;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cap_depth_q == 8'd0) begin
                    rsp_done_d = grant_onehot;
                    rsp_err_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    m_start_d   = 1'b1;
                    m_dir_d     = cap_dir_q;
                    m_data_tx_d = cap_data_q;
                    m_depth_d   = cap_depth_q;
                    cnt_d       = '0;
                    state_d     = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!m_ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                        rsp_done_d = grant_onehot;
                        rsp_err_d  = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (m_ready) begin
                    rsp_data_d = m_rx_data;
                    rsp_done_d = grant_onehot;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                // rsp_err_q is high exactly during DONE when the word was aborted.
                lock_active_d = cap_lock_q & ~rsp_err_q;
                if (!cap_lock_q) begin
                    rr_ptr_d = rr_next;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            lock_active_q <= 1'b0;
            cnt_q         <= '0;
            cap_dir_q     <= 1'b0;
            cap_lock_q    <= 1'b0;
            cap_data_q    <= '0;
            cap_depth_q   <= '0;
            req_ready_q   <= '0;
            rsp_done_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            m_start_q     <= 1'b0;
            m_dir_q       <= 1'b0;
            m_data_tx_q   <= '0;
            m_depth_q     <= '0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_active_q <= lock_active_d;
            cnt_q         <= cnt_d;
            cap_dir_q     <= cap_dir_d;
            cap_lock_q    <= cap_lock_d;
            cap_data_q    <= cap_data_d;
            cap_depth_q   <= cap_depth_d;
            req_ready_q   <= req_ready_d;
            rsp_done_q    <= rsp_done_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            m_start_q     <= m_start_d;
            m_dir_q       <= m_dir_d;
            m_data_tx_q   <= m_data_tx_d;
            m_depth_q     <= m_depth_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign m_start   = m_start_q;
    assign m_dir     = m_dir_q;
    assign m_data_tx = m_data_tx_q;
    assign m_depth   = m_depth_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master engine between NUM_REQ requesters: ADF4002 init, LMX2594 init, FPGA SPI debug writes, and future sources.
- Arbitration is round-robin, one transaction (one SPI word) at a time.
- Supports bus locking, so a multi-word register load cannot be interleaved with other requesters' words.
- Sits between the process/control FSM and the SPI master; it replaces the per-target spi_start/spi_ready fan-out with request/response handshakes.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 24, SPI word width in bits.
- START_TIMEOUT, 16, cycles allowed for m_ready to fall after m_start before the transaction is aborted with an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request; held with its payload until req_ready.
- req_dir  in  NUM_REQ  per-requester direction (0 = write).
- req_lock  in  NUM_REQ  keep the bus for this requester after this word.
- req_data  in  NUM_REQ*DATA_W  TX words; requester i uses bits [i*DATA_W +: DATA_W].
- req_depth  in  NUM_REQ*8  bit counts; requester i uses bits [i*8 +: 8].
- req_ready  out  NUM_REQ  one-cycle accept pulse.
- rsp_done  out  NUM_REQ  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_done: 1 means aborted.
- rsp_data  out  DATA_W  captured m_rx_data; valid with rsp_done.
- m_ready  in  1  SPI master idle (high = idle).
- m_rx_data  in  DATA_W  SPI master receive word.
- m_start  out  1  one-cycle start pulse.
- m_dir  out  1  direction to the master.
- m_data_tx  out  DATA_W  word to the master.
- m_depth  out  8  bit count to the master.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of the current or last granted requester.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state = IDLE; rr_ptr = 0; lock_active = 0; timeout counter = 0.
- A reset in any state returns to IDLE immediately. No rsp_done is issued for an in-flight word.
- After reset the block waits for m_ready = 1 before any grant, which lets the master drain naturally.

States:
- IDLE:
  - Acts only when m_ready = 1 and at least one request is eligible.
  - If lock_active = 1, only grant_id is eligible.
  - Otherwise, the first set req_valid bit searching upward from rr_ptr, with wrap-around, wins.
  - On the grant edge: req_ready[g] is set for 1 cycle; dir, data, depth and lock for g are captured; grant_id = g; state -> ISSUE.
  - If the captured depth is 0: no m_start; go directly to DONE with err = 1.
  - If the captured depth exceeds DATA_W, it is clamped to DATA_W.
- ISSUE:
  - m_start = 1 for exactly 1 cycle.
  - m_dir, m_data_tx and m_depth are driven from the captured values and held stable until the next grant.
  - state -> WAIT_BUSY; counter cleared.
- WAIT_BUSY:
  - On m_ready = 0: state -> WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches START_TIMEOUT: state -> DONE with err = 1.
- WAIT_DONE:
  - On m_ready = 1: rsp_data is set from m_rx_data; state -> DONE with err = 0.
  - There is no timeout in this state.
- DONE:
  - rsp_done[grant_id] = 1 and rsp_err = err, for 1 cycle.
  - lock_active is set to the captured lock. If err = 1, lock_active is cleared.
  - If the captured lock is 0: rr_ptr = grant_id + 1, wrapping to 0 at NUM_REQ.
  - state -> IDLE.

Timing and rules:
- Latency from req_valid sampled high in IDLE with the bus free: req_ready at +1 cycle, m_start at +2. The minimum turnaround between back-to-back grants is 5 cycles plus the SPI time.
- A requester drops req_valid, or presents its next word, in the cycle after it sees req_ready. A valid held over an accepted word is treated as a new request.
- Simultaneous requests are resolved by rr_ptr order. A requester is never granted twice in a row while others wait, except under lock.
- A locked requester that drops req_valid keeps the lock. Other requesters starve until it issues a word with req_lock = 0 or suffers an error.
- rsp_done and req_ready never pulse for two requesters in the same cycle.

Test Plan:
- Reset, then req_valid = 3'b001, data 24'h1F8093, depth 24, with m_ready modelled low for 24 cycles after start: req_ready[0] at +1; m_start at +2 with m_data_tx = 1F8093 and m_depth = 24; rsp_done[0] with rsp_err = 0 one cycle after m_ready rises; busy low afterwards.
- All three requesters valid continuously, each dropping and re-raising valid after accept: grant order is 0, 1, 2, 0, 1, 2; grant_id follows that order; no double pulses.
- Requester 1 issues 113 words with req_lock = 1 except the last, while requester 2 stays valid: all 113 words go to requester 1 back-to-back; requester 2 is granted only after the unlocked last word.
- m_ready held high after m_start: rsp_done[g] with rsp_err = 1 after 16 cycles in WAIT_BUSY; a subsequent request is granted normally; any lock is cleared.
- Request with req_depth = 0: req_ready pulses, m_start never pulses, rsp_done with rsp_err = 1. Request with depth = 40: m_depth = 24.
- Assert rst during WAIT_DONE: all outputs 0 on the next cycle; no rsp_done; a pending req_valid is granted only after m_ready returns high, and the grant goes to requester 0 first.
